// File: rtl/rd_popcount_pipe.sv
// rd_popcount_pipe: two-stage ones counter with a saturating per-frame running sum.
// Latency 2 clocks from input handshake to out_valid; throughput 1 beat per clock.
// Backpressure: out_ready low freezes S2 and holds one beat in S1, then in_ready drops. Macro RDP_THRESH_EN adds out_ge.
module rd_popcount_pipe #(
  parameter int N_IN   = 5,
  parameter int GROUP  = 4,
  parameter int ACC_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_ge
);
  localparam int CW  = $clog2(N_IN + 1);
  localparam int NG  = (N_IN + GROUP - 1) / GROUP;
  localparam int PW  = $clog2(GROUP + 1);
  localparam int AW1 = ACC_W + 1;
  localparam logic [ACC_W:0] MAXV = {1'b0, {ACC_W{1'b1}}};

  logic              r_s1_valid;
  logic              r_s1_last;
  logic [PW-1:0]     r_s1_part [NG];
  logic              r_s2_valid;
  logic [ACC_W-1:0]  r_out_count;
  logic              r_out_sat;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sat;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_ready;
  logic [NG*GROUP-1:0] w_pad;
  logic [PW-1:0]     w_part [NG];
  logic [CW-1:0]     w_cnt;
  logic [ACC_W:0]    w_nsum;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_result;
  logic              w_sat_n;

  assign w_s2_adv   = !r_s2_valid | out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_adv;
  assign w_in_ready = !r_s1_valid | w_s2_adv;

  // Pad to a whole number of groups so the last partial adder sees zeros.
  always_comb begin
    w_pad = '0;
    w_pad[N_IN-1:0] = in_data;
    for (int g = 0; g < NG; g++) begin
      w_part[g] = '0;
      for (int b = 0; b < GROUP; b++) begin
        w_part[g] = w_part[g] + PW'(w_pad[g*GROUP+b]);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int g = 0; g < NG; g++) begin
      w_cnt = w_cnt + CW'(r_s1_part[g]);
    end
  end

  assign w_nsum   = {1'b0, r_acc} + AW1'(w_cnt);
  assign w_ovf    = w_nsum > MAXV;
  assign w_result = w_ovf ? MAXV[ACC_W-1:0] : w_nsum[ACC_W-1:0];
  assign w_sat_n  = r_sat | w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int g = 0; g < NG; g++) r_s1_part[g] <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_last <= in_last;
        for (int g = 0; g < NG; g++) r_s1_part[g] <= w_part[g];
      end
    end
  end

  // Mid-frame beats fold into acc without raising out_valid; last beats publish and restart the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid & r_s1_last;
      if (w_s1_adv) begin
        if (r_s1_last) begin
          r_out_count <= w_result;
          r_out_sat   <= w_sat_n;
          r_acc       <= '0;
          r_sat       <= 1'b0;
        end else begin
          r_acc <= w_result;
          r_sat <= w_sat_n;
        end
      end
    end
  end

`ifdef RDP_THRESH_EN
  localparam logic [ACC_W-1:0] THR = ACC_W'(THRESH);
  logic r_out_ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_ge <= 1'b0;
    end else if (w_s1_adv && r_s1_last) begin
      r_out_ge <= (w_result >= THR);
    end
  end

  assign out_ge = r_out_ge;
`else
  assign out_ge = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule
